// File: rtl/fp_pkg.sv
// Shared FP32 definitions: the reduction sequencer's state encoding and the FP32
// constants and field widths used around the external adder.
package fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'hFFC0_0000;

    localparam int FP32_W     = 32;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

endpackage

// File: rtl/fp32_reduce_seq_if.sv
// Bundles the element input stream, the adder operand/result bus and the result stream.
// The slave modport is the reduction block; the master modport is its environment.
interface fp32_reduce_seq_if #(
    parameter int CNT_W = 16
);
    import fp_pkg::*;

    // Both streams use valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both high; the producer holds data stable until then.
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;

    logic             add_en;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_z;
    logic             add_ready;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    state_t           dbg_state;

    modport master (
        output in_valid, in_data, in_last, add_z, add_ready, out_ready,
        input  in_ready, add_en, add_a, add_b, out_valid, out_sum, out_count, out_err,
        input  dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, add_z, add_ready, out_ready,
        output in_ready, add_en, add_a, add_b, out_valid, out_sum, out_count, out_err,
        output dbg_state
    );

endinterface

// File: rtl/fp32_reduce_seq.sv
// Sequences a last-framed FP32 stream through an external registered adder, feeding the
// running sum back as operand A, and returns the sum with an element count.
module fp32_reduce_seq
    import fp_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    fp32_reduce_seq_if.slave   bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [31:0]        acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               last_q;
    logic               err;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               in_ready_q;
    logic               out_valid_q;
    logic [31:0]        out_sum_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_err_q;
    logic               acc_phase;

    assign cnt_next  = (&cnt) ? cnt : cnt + 1'b1;
    assign acc_phase = (state == ST_ACC);

    // Operands are combinational so the adder captures them on the same edge the element is accepted.
    assign bus.add_en    = acc_phase & bus.in_valid;
    assign bus.add_a     = acc_phase ? acc : FP32_ZERO;
    assign bus.add_b     = acc_phase ? bus.in_data : FP32_ZERO;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_err   = out_err_q;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= FP32_ZERO;
            cnt         <= '0;
            last_q      <= 1'b0;
            err         <= 1'b0;
            wait_cnt    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= FP32_ZERO;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        acc <= bus.in_data;
                        cnt <= CNT_W'(1);
                        if (bus.in_last) begin
                            state       <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_sum_q   <= bus.in_data;
                            out_count_q <= CNT_W'(1);
                            out_err_q   <= err;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end

                ST_ACC: begin
                    if (bus.in_valid) begin
                        cnt        <= cnt_next;
                        last_q     <= bus.in_last;
                        wait_cnt   <= '0;
                        state      <= ST_WAIT;
                        in_ready_q <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (bus.add_ready) begin
                        acc <= bus.add_z;
                        if (last_q) begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_sum_q   <= bus.add_z;
                            out_count_q <= cnt;
                            out_err_q   <= err;
                        end else begin
                            state      <= ST_ACC;
                            in_ready_q <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        // Abort keeps the last good accumulator as the reported sum.
                        err         <= 1'b1;
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_sum_q   <= acc;
                        out_count_q <= cnt;
                        out_err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        err         <= 1'b0;
                        last_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_reduce_seq.sv
// Directed bench for fp32_reduce_seq with a lookup-table stand-in for the registered
// FP32 adder (result and add_ready one cycle after add_en).
module tb_fp32_reduce_seq;
    import fp_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_reduce_seq_if #(.CNT_W(CNT_W)) bus ();

    fp32_reduce_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   add_pulses = 0;
    int   wait_viol = 0;
    logic adder_on = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.add_en) add_pulses <= add_pulses + 1;
    always @(negedge clk) if (bus.dbg_state == ST_WAIT && bus.in_ready) wait_viol <= wait_viol + 1;

    // Hand-computed FP32 sums for every operand pair the vectors produce.
    function automatic logic [31:0] fp_add_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_40400000: return 32'h40C00000;
            64'h3F800000_BF800000: return 32'h00000000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_3F800000: return 32'h40400000;
            64'h40400000_3F800000: return 32'h40800000;
            64'h40800000_3F800000: return 32'h40A00000;
            64'h40A00000_3F800000: return 32'h40C00000;
            64'h40000000_40000000: return 32'h40800000;
            default:               return FP32_QNAN;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.add_ready <= 1'b0;
        if (bus.add_en && adder_on) begin
            bus.add_z     <= fp_add_lut(bus.add_a, bus.add_b);
            bus.add_ready <= 1'b1;
        end
    end

    // Returns the posedge count of the accepting edge, read on the following negedge.
    task automatic send(input logic [31:0] d, input logic l, input int gap, output int hs);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_stall in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
        end
        @(negedge clk);
        hs = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int seen);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL out_timeout out_valid=%b after %0d cycles, want 1", bus.out_valid, n);
        end
        seen = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        total++; if (bus.out_sum !== 32'h0) begin bad++; $display("FAIL rst_out_sum got %h want 0", bus.out_sum); end
        total++; if (bus.out_count !== 16'd0) begin bad++; $display("FAIL rst_out_count got %0d want 0", bus.out_count); end
        total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got %b want 0", bus.out_err); end
        total++; if ({bus.add_en, bus.add_a, bus.add_b} !== 65'h0) begin bad++; $display("FAIL rst_add_bus got %b/%h/%h want 0", bus.add_en, bus.add_a, bus.add_b); end
        total++; if (bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got %0d want 0", bus.dbg_state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 1+2+3: first handshake in cycle 1, DONE in cycle 5, i.e. four edges later.
    task automatic test_sum3();
        int h0, h1, h2, seen, p0;
        p0 = add_pulses;
        send(32'h3F800000, 1'b0, 0, h0);
        send(32'h40000000, 1'b0, 0, h1);
        send(32'h40400000, 1'b1, 0, h2);
        wait_out(seen);
        total++; if (bus.out_sum !== 32'h40C00000) begin bad++; $display("FAIL sum3_sum got %h want 40c00000", bus.out_sum); end
        total++; if (bus.out_count !== 16'd3) begin bad++; $display("FAIL sum3_count got %0d want 3", bus.out_count); end
        total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL sum3_err got %b want 0", bus.out_err); end
        total++; if (add_pulses - p0 !== 2) begin bad++; $display("FAIL sum3_add_pulses got %0d want 2", add_pulses - p0); end
        total++; if (seen - h0 !== 4) begin bad++; $display("FAIL sum3_latency got %0d want 4", seen - h0); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int h0, seen, p0;
        p0 = add_pulses;
        send(32'h40490FDB, 1'b1, 0, h0);
        wait_out(seen);
        total++; if (seen - h0 !== 0) begin bad++; $display("FAIL single_latency got %0d want 0", seen - h0); end
        total++; if (bus.out_sum !== 32'h40490FDB) begin bad++; $display("FAIL single_sum got %h want 40490fdb", bus.out_sum); end
        total++; if (bus.out_count !== 16'd1) begin bad++; $display("FAIL single_count got %0d want 1", bus.out_count); end
        total++; if (add_pulses - p0 !== 0) begin bad++; $display("FAIL single_add_pulses got %0d want 0", add_pulses - p0); end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int h0, h1, seen;
        bus.out_ready = 1'b0;
        send(32'h3F800000, 1'b0, 0, h0);
        send(32'hBF800000, 1'b1, 0, h1);
        wait_out(seen);
        for (int i = 0; i < 10; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_flags[%0d] got valid=%b ready=%b want 1/0", i, bus.out_valid, bus.in_ready); end
            total++; if (bus.out_sum !== 32'h0 || bus.out_err !== 1'b0) begin bad++; $display("FAIL hold_sum[%0d] got %h err=%b want 0 err=0", i, bus.out_sum, bus.out_err); end
            total++; if (bus.out_count !== 16'd2) begin bad++; $display("FAIL hold_count[%0d] got %0d want 2", i, bus.out_count); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_timeout();
        int h0, h1, seen;
        adder_on = 1'b0;
        send(32'h40000000, 1'b0, 0, h0);
        send(32'h40000000, 1'b0, 0, h1);
        wait_out(seen);
        total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL tmo_err got %b want 1", bus.out_err); end
        total++; if (bus.out_sum !== 32'h40000000) begin bad++; $display("FAIL tmo_sum got %h want 40000000", bus.out_sum); end
        total++; if (bus.out_count !== 16'd2) begin bad++; $display("FAIL tmo_count got %0d want 2", bus.out_count); end
        total++; if (seen - h1 !== TIMEOUT) begin bad++; $display("FAIL tmo_wait_cycles got %0d want %0d", seen - h1, TIMEOUT); end
        adder_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int h0, h1, h2, seen, p0;
        send(32'h40000000, 1'b0, 0, h0);
        send(32'h40000000, 1'b0, 0, h1);
        total++; if (bus.dbg_state !== ST_WAIT) begin bad++; $display("FAIL mid_in_wait got %0d want 2", bus.dbg_state); end
        rst = 1'b1;
        #1;
        total++; if (bus.out_sum !== 32'h0 || bus.out_err !== 1'b0) begin bad++; $display("FAIL mid_rst_sum got %h err=%b want 0 err=0", bus.out_sum, bus.out_err); end
        total++; if (bus.out_count !== 16'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_count got %0d valid=%b want 0/0", bus.out_count, bus.out_valid); end
        total++; if (bus.dbg_state !== ST_IDLE || bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_state got %0d ready=%b want 0/1", bus.dbg_state, bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        p0 = add_pulses;
        send(32'h40A00000, 1'b1, 0, h2);
        wait_out(seen);
        total++; if (bus.out_sum !== 32'h40A00000) begin bad++; $display("FAIL mid_after_sum got %h want 40a00000", bus.out_sum); end
        total++; if (bus.out_count !== 16'd1 || bus.out_err !== 1'b0) begin bad++; $display("FAIL mid_after_count got %0d err=%b want 1 err=0", bus.out_count, bus.out_err); end
        total++; if (add_pulses - p0 !== 0) begin bad++; $display("FAIL mid_after_pulses got %0d want 0", add_pulses - p0); end
        @(negedge clk);
    endtask

    task automatic test_gaps();
        int hs, seen, p0, v0;
        p0 = add_pulses;
        v0 = wait_viol;
        for (int i = 0; i < 6; i++) begin
            send(32'h3F800000, (i == 5), $urandom_range(0, 3), hs);
        end
        wait_out(seen);
        total++; if (bus.out_sum !== 32'h40C00000) begin bad++; $display("FAIL gaps_sum got %h want 40c00000", bus.out_sum); end
        total++; if (bus.out_count !== 16'd6 || bus.out_err !== 1'b0) begin bad++; $display("FAIL gaps_count got %0d err=%b want 6 err=0", bus.out_count, bus.out_err); end
        total++; if (add_pulses - p0 !== 5) begin bad++; $display("FAIL gaps_pulses got %0d want 5", add_pulses - p0); end
        total++; if (wait_viol !== v0) begin bad++; $display("FAIL gaps_ready_in_wait got %0d want %0d", wait_viol, v0); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sum3();
        test_single();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
